gp_countn_adv: RTL

GP_COUNTN_ADV -- requirements
Module: GP_COUNTN_ADV

---
 rtl/gp_countn_adv.sv | 111 +++++++++++
 1 files changed

// File: rtl/gp_countn_adv.sv
// rtl/gp_countn_adv.sv - up/down counter with wrap or one-shot mode, load, hold and terminal pulse
module gp_countn_adv #(
    parameter int    WIDTH       = 14,
    parameter int    COUNT_TO    = 1,
    parameter string RESET_VALUE = "ZERO",
    parameter string MODE        = "WRAP"
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP,
    input  logic             KEEP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             START,
    output logic             OUT,
    output logic [WIDTH-1:0] POUT,
    output logic             PULSE,
    output logic             BUSY
);

    // Reject unsupported configurations before anything runs.
    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $fatal(1, "gp_countn_adv: WIDTH %0d outside 2..16", WIDTH);
        end
        if (RESET_VALUE != "ZERO" && RESET_VALUE != "COUNT_TO") begin : g_bad_rst
            $fatal(1, "gp_countn_adv: RESET_VALUE must be ZERO or COUNT_TO");
        end
        if (MODE != "WRAP" && MODE != "ONESHOT") begin : g_bad_mode
            $fatal(1, "gp_countn_adv: MODE must be WRAP or ONESHOT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM    = COUNT_TO[WIDTH-1:0];
    localparam bit               ONESHOT = (MODE == "ONESHOT");
    localparam logic [WIDTH-1:0] RST_CNT = (RESET_VALUE == "COUNT_TO") ? TERM : '0;
    // WRAP mode parks permanently in RUN; only ONESHOT uses IDLE/DONE.
    localparam state_t           RST_ST  = ONESHOT ? S_IDLE : S_RUN;

    // Power-on values; RST later forces RESET_VALUE instead.
    logic [WIDTH-1:0] count = TERM;
    state_t           state = RST_ST;
    logic             pulse_q = 1'b0;

    logic [WIDTH-1:0] count_n;
    state_t           state_n;
    logic             pulse_n;
    logic             term;

    // Terminal flag follows the live direction input.
    assign term  = UP ? ((count == TERM) || (count == {WIDTH{1'b1}})) : (count == '0);
    assign OUT   = term;
    assign POUT  = count;
    assign PULSE = pulse_q;
    assign BUSY  = ONESHOT ? (state == S_RUN) : !RST;

    // Next count, state and pulse: LOAD > KEEP > START > step.
    always_comb begin
        count_n = count;
        state_n = state;
        pulse_n = 1'b0;
        if (LOAD) begin
            count_n = LOAD_VAL;
            if (ONESHOT && state == S_DONE) begin
                state_n = S_RUN;
            end
        end else if (KEEP) begin
            count_n = count;
        end else if (ONESHOT) begin
            if (state != S_RUN) begin
                if (START) begin
                    count_n = UP ? '0 : TERM;
                    state_n = S_RUN;
                end
            end else if (term) begin
                // Stop on the terminal value instead of wrapping.
                state_n = S_DONE;
                pulse_n = 1'b1;
            end else begin
                count_n = UP ? count + 1'b1 : count - 1'b1;
            end
        end else begin
            if (term) begin
                count_n = UP ? '0 : TERM;
                pulse_n = 1'b1;
            end else begin
                count_n = UP ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    // Registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count   <= RST_CNT;
            state   <= RST_ST;
            pulse_q <= 1'b0;
        end else begin
            count   <= count_n;
            state   <= state_n;
            pulse_q <= pulse_n;
        end
    end

endmodule
